// File: rtl/seq_shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-add multiplier with valid/ready handshakes on both sides.
// A single 8-bit ripple-carry adder does one partial-product step per cycle, then rounds the upper byte.

module adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[WIDTH];
    end

endmodule

module seq_shift_add_multiplier #(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic [7:0]  prod_hi,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  q_q, q_d;
    logic        c_q, c_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] prod_q, prod_d;
    logic [7:0]  prod_hi_q, prod_hi_d;

    logic [7:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;

    adder #(.WIDTH(8)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    // Adder operands depend only on registered state, kept apart from next-state logic
    // so the adder output never feeds back into its own input process.
    always_comb begin
        add_a   = acc_q;
        add_b   = 8'h00;
        add_cin = 1'b0;
        case (state_q)
            S_CALC: begin
                add_b   = q_q[0] ? m_q : 8'h00;
                add_cin = c_q;  // cleared on accept and refilled with 0 every step
            end
            S_ROUND: add_cin = ROUND_EN & q_q[7];
            default: ;
        endcase
    end

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        prod_hi_d = prod_hi_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = 8'h00;
                    c_d     = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                {c_d, acc_d, q_d} = {add_cout, add_s, q_q} >> 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                prod_d    = {acc_q, q_q};
                prod_hi_d = add_s;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= 8'h00;
            acc_q     <= 8'h00;
            q_q       <= 8'h00;
            c_q       <= 1'b0;
            cnt_q     <= 3'd0;
            prod_q    <= 16'h0000;
            prod_hi_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            prod_hi_q <= prod_hi_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) || (state_q == S_ROUND);
    assign prod      = prod_q;
    assign prod_hi   = prod_hi_q;

endmodule
